// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file with per-register RW / RO / W1C behaviour,
// byte strobes, independent AW/W acceptance and SLVERR on out-of-range indices.
module axi_lite_regfile #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter int          NUM_REGS           = 16,
  parameter logic [63:0] RO_MASK            = 64'd0,
  parameter logic [63:0] W1C_MASK           = 64'd0
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_rd_data,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_set,
  output logic [NUM_REGS-1:0]                    wr_pulse
);

  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int AW  = C_S_AXI_ADDR_WIDTH;
  localparam int NB  = DW / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = AW - LSB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t            r_wstate, w_wstate_nxt;
  r_state_t            r_rstate, w_rstate_nxt;
  logic                r_init;
  logic                r_aw_held, r_w_held;
  logic [IW-1:0]       r_aw_idx;
  logic [DW-1:0]       r_wdata;
  logic [NB-1:0]       r_wstrb;
  logic [1:0]          r_bresp, r_rresp;
  logic [DW-1:0]       r_rdata;
  logic [DW-1:0]       r_regs    [NUM_REGS];
  logic [DW-1:0]       w_reg_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] r_wr_hit, r_wr_pulse;

  logic                w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [IW-1:0]       w_wr_idx, w_rd_idx;
  logic [DW-1:0]       w_wr_data, w_rd_data;
  logic [NB-1:0]       w_wr_strb;
  logic                w_wr_ok, w_rd_ok;
  logic                w_unused;

  // Ready/valid come only from registered state so no input reaches them.
  assign S_AXI_AWREADY = (r_wstate == W_IDLE) && r_init && !r_aw_held;
  assign S_AXI_WREADY  = (r_wstate == W_IDLE) && r_init && !r_w_held;
  assign S_AXI_BVALID  = (r_wstate == W_RESP);
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = (r_rstate == R_IDLE) && r_init;
  assign S_AXI_RVALID  = (r_rstate == R_DATA);
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign wr_pulse      = r_wr_pulse;

  assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // A held slot wins over the live bus; otherwise the beat completing now is used.
  assign w_wr_idx  = r_aw_held ? r_aw_idx : S_AXI_AWADDR[AW-1:LSB];
  assign w_wr_data = r_w_held  ? r_wdata  : S_AXI_WDATA;
  assign w_wr_strb = r_w_held  ? r_wstrb  : S_AXI_WSTRB;
  assign w_wr_ok   = int'(w_wr_idx) < NUM_REGS;
  assign w_rd_idx  = S_AXI_ARADDR[AW-1:LSB];
  assign w_rd_ok   = int'(w_rd_idx) < NUM_REGS;

  // Protection bits and sub-word address bits carry no meaning here.
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                      S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

  // State registers for both channels plus the post-reset ready enable.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
      r_init   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
      r_init   <= 1'b1;
    end
  end

  // Write FSM: commit once both AW and W are available, then hold B until BREADY.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_wstate_nxt = r_wstate;
    w_commit     = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: if (S_AXI_BREADY) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Read FSM: capture on AR handshake, hold R until RREADY.
  always_comb begin
    w_rstate_nxt = r_rstate;
    unique case (r_rstate)
      R_IDLE:  if (w_ar_hs)      w_rstate_nxt = R_DATA;
      R_DATA:  if (S_AXI_RREADY) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // One-entry AW and W slots and the registered write response.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= S_AXI_AWADDR[AW-1:LSB];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= S_AXI_WDATA;
        r_wstrb  <= S_AXI_WSTRB;
      end
    end
  end

  // Next register values: strobed bus write (replace or W1C), then hardware set wins.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_reg_nxt[i] = r_regs[i];
      if (w_commit && w_wr_ok && (int'(w_wr_idx) == i)) begin
        for (int b = 0; b < NB; b++) begin
          if (w_wr_strb[b]) begin
            w_reg_nxt[i][b*8 +: 8] = W1C_MASK[i] ? (r_regs[i][b*8 +: 8] & ~w_wr_data[b*8 +: 8])
                                                 : w_wr_data[b*8 +: 8];
          end
        end
      end
      if (W1C_MASK[i]) w_reg_nxt[i] = w_reg_nxt[i] | hw_set[i*DW +: DW];
    end
  end

  // Register storage and the two-stage write strobe (update edge, then pulse).
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      // NOTE: the register file is built from flops, not RAM, so it takes the async reset like any other state.
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_wr_hit   <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= r_wr_hit;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_wr_hit[i] <= w_commit && w_wr_ok && (int'(w_wr_idx) == i);
        if (!RO_MASK[i]) r_regs[i] <= w_reg_nxt[i];
      end
    end
  end

  // Read source select: RO slots come from hardware, others from storage.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(w_rd_idx) == i) w_rd_data = RO_MASK[i] ? hw_rd_data[i*DW +: DW] : r_regs[i];
    end
  end

  // Read data/response capture at the AR handshake.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd_ok ? w_rd_data : '0;
      r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Flatten storage onto reg_out.
  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_out[i*DW +: DW] = r_regs[i];
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Bench for axi_lite_regfile: a default 16-register instance and a 4-register
// instance with one W1C and one RO register, sharing one set of bus drivers.
module tb_axi_lite_regfile;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef struct { logic [1:0] resp; logic [15:0] pulse; } b_exp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } r_exp_t;

  b_exp_t b_q[$];
  r_exp_t r_q[$];
  int     n_checks = 0;
  int     n_errors = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [5:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic        awready_a, wready_a, bvalid_a, arready_a, rvalid_a;
  logic [1:0]  bresp_a, rresp_a;
  logic [31:0] rdata_a;
  logic [511:0] reg_out_a;
  logic [15:0] wr_pulse_a;

  logic        awready_b, wready_b, bvalid_b, arready_b, rvalid_b;
  logic [1:0]  bresp_b, rresp_b;
  logic [31:0] rdata_b;
  logic [127:0] reg_out_b, hw_rd_b, hw_set_b;
  logic [3:0]  wr_pulse_b;

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [15:0] pulse;

  assign awready = sel ? awready_b : awready_a;
  assign wready  = sel ? wready_b  : wready_a;
  assign bvalid  = sel ? bvalid_b  : bvalid_a;
  assign bresp   = sel ? bresp_b   : bresp_a;
  assign arready = sel ? arready_b : arready_a;
  assign rvalid  = sel ? rvalid_b  : rvalid_a;
  assign rdata   = sel ? rdata_b   : rdata_a;
  assign rresp   = sel ? rresp_b   : rresp_a;
  assign pulse   = sel ? {12'd0, wr_pulse_b} : wr_pulse_a;

  always #5 clk = ~clk;

  axi_lite_regfile u_dut_a (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid & ~sel), .S_AXI_AWREADY(awready_a),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid & ~sel), .S_AXI_WREADY(wready_a),
    .S_AXI_BRESP(bresp_a), .S_AXI_BVALID(bvalid_a), .S_AXI_BREADY(bready & ~sel),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid & ~sel), .S_AXI_ARREADY(arready_a),
    .S_AXI_RDATA(rdata_a), .S_AXI_RRESP(rresp_a), .S_AXI_RVALID(rvalid_a), .S_AXI_RREADY(rready & ~sel),
    .reg_out(reg_out_a), .hw_rd_data(512'd0), .hw_set(512'd0), .wr_pulse(wr_pulse_a)
  );

  axi_lite_regfile #(.NUM_REGS(4), .RO_MASK(64'h8), .W1C_MASK(64'h2)) u_dut_b (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid & sel), .S_AXI_AWREADY(awready_b),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid & sel), .S_AXI_WREADY(wready_b),
    .S_AXI_BRESP(bresp_b), .S_AXI_BVALID(bvalid_b), .S_AXI_BREADY(bready & sel),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid & sel), .S_AXI_ARREADY(arready_b),
    .S_AXI_RDATA(rdata_b), .S_AXI_RRESP(rresp_b), .S_AXI_RVALID(rvalid_b), .S_AXI_RREADY(rready & sel),
    .reg_out(reg_out_b), .hw_rd_data(hw_rd_b), .hw_set(hw_set_b), .wr_pulse(wr_pulse_b)
  );

  // One write: W first, AW after aw_delay cycles, BREADY held low b_stall cycles.
  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] resp, input logic [15:0] exp_pulse,
                           input int aw_delay, input int b_stall);
    b_exp_t e;
    logic   aw_hs, w_hs, aw_sent;
    int     n;
    e.resp = resp;
    e.pulse = exp_pulse;
    b_q.push_back(e);
    @(negedge clk);
    wdata = d; wstrb = s; wvalid = 1'b1;
    awaddr = a; aw_sent = (aw_delay == 0); awvalid = aw_sent;
    n = 0;
    while ((awvalid || wvalid || !aw_sent) && n < 100) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      n++;
      if (!aw_sent && !wvalid) begin
        n_checks++;
        if (wready !== 1'b0 || bvalid !== 1'b0) begin
          n_errors++;
          $display("FAIL wr_w_held: wready=%b bvalid=%b, want 0/0", wready, bvalid);
        end
      end
      if (!aw_sent && n >= aw_delay) begin awvalid = 1'b1; aw_sent = 1'b1; end
      @(negedge clk);
    end
    n_checks++;
    if (awvalid || wvalid) begin
      n_errors++;
      $display("FAIL wr_timeout: addr=%h not accepted", a);
      awvalid = 1'b0; wvalid = 1'b0;
    end
    e = b_q.pop_front();
    n_checks++;
    if (bvalid !== 1'b1 || pulse !== 16'd0) begin
      n_errors++;
      $display("FAIL wr_latency: bvalid=%b wr_pulse=%h, want 1/0000", bvalid, pulse);
    end
    n_checks++;
    if (bresp !== e.resp) begin
      n_errors++;
      $display("FAIL wr_bresp: addr=%h got %b want %b", a, bresp, e.resp);
    end
    for (int k = 0; k < b_stall; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_checks++;
        if (pulse !== e.pulse) begin
          n_errors++;
          $display("FAIL wr_pulse: got %h want %h", pulse, e.pulse);
        end
      end
      n_checks++;
      if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b1 || bresp !== e.resp) begin
        n_errors++;
        $display("FAIL wr_stall: awready=%b wready=%b bvalid=%b bresp=%b, want 0/0/1/%b",
                 awready, wready, bvalid, bresp, e.resp);
      end
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    if (b_stall == 0) begin
      n_checks++;
      if (pulse !== e.pulse) begin
        n_errors++;
        $display("FAIL wr_pulse: got %h want %h", pulse, e.pulse);
      end
    end
    n_checks++;
    if (bvalid !== 1'b0) begin
      n_errors++;
      $display("FAIL wr_bdone: bvalid=%b want 0", bvalid);
    end
  endtask

  // One read with RREADY held low r_stall cycles.
  task automatic axi_read(input logic [5:0] a, input logic [31:0] d, input logic [1:0] resp,
                          input int r_stall);
    r_exp_t e;
    logic   hs;
    int     n;
    e.data = d;
    e.resp = resp;
    r_q.push_back(e);
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (arvalid && n < 100) begin
      hs = arvalid && arready;
      @(posedge clk); #1;
      if (hs) arvalid = 1'b0;
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (arvalid) begin
      n_errors++;
      $display("FAIL rd_timeout: addr=%h not accepted", a);
      arvalid = 1'b0;
    end
    e = r_q.pop_front();
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== e.data || rresp !== e.resp) begin
      n_errors++;
      $display("FAIL rd_data: addr=%h rvalid=%b rdata=%h rresp=%b, want 1/%h/%b",
               a, rvalid, rdata, rresp, e.data, e.resp);
    end
    for (int k = 0; k < r_stall; k++) begin
      @(negedge clk);
      n_checks++;
      if (arready !== 1'b0 || rvalid !== 1'b1 || rdata !== e.data) begin
        n_errors++;
        $display("FAIL rd_stall: arready=%b rvalid=%b rdata=%h, want 0/1/%h", arready, rvalid, rdata, e.data);
      end
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b0) begin
      n_errors++;
      $display("FAIL rd_done: rvalid=%b want 0", rvalid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (awready !== 1'b0 || wready !== 1'b0 || arready !== 1'b0 || bvalid !== 1'b0 || rvalid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_hs: aw=%b w=%b ar=%b b=%b r=%b, want all 0", awready, wready, arready, bvalid, rvalid);
    end
    n_checks++;
    if (bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'd0 || reg_out_a !== 512'd0 || pulse !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_vals: bresp=%b rresp=%b rdata=%h wr_pulse=%h, want zeros", bresp, rresp, rdata, pulse);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release: aw=%b w=%b ar=%b, want 1/1/1", awready, wready, arready);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) axi_write(6'(i * 4), 32'(i + 1), 4'hF, OKAY, 16'(1 << i), 0, 0);
    for (int i = 0; i < 4; i++) axi_read(6'(i * 4), 32'(i + 1), OKAY, 0);
  endtask

  task automatic test_strobe();
    axi_write(6'h00, 32'hFFFF_FFFF, 4'hF, OKAY, 16'h0001, 0, 0);
    axi_write(6'h00, 32'h0000_00AB, 4'h1, OKAY, 16'h0001, 0, 0);
    axi_read(6'h00, 32'hFFFF_FFAB, OKAY, 0);
    axi_write(6'h00, 32'h1234_5678, 4'h0, OKAY, 16'h0001, 0, 0);
    axi_read(6'h00, 32'hFFFF_FFAB, OKAY, 1);
    axi_write(6'h05, 32'h1122_3344, 4'h6, OKAY, 16'h0002, 0, 0);
    axi_read(6'h07, 32'h0022_3302, OKAY, 0);
  endtask

  task automatic test_parallel();
    fork
      axi_write(6'h08, 32'h0000_0099, 4'hF, OKAY, 16'h0004, 0, 0);
      axi_read(6'h08, 32'h0000_0003, OKAY, 0);
    join
    axi_read(6'h08, 32'h0000_0099, OKAY, 0);
  endtask

  task automatic test_back_to_back_stall();
    axi_write(6'h0C, 32'h0000_0077, 4'hF, OKAY, 16'h0008, 3, 5);
    axi_write(6'h0C, 32'h0000_0078, 4'hF, OKAY, 16'h0008, 0, 0);
    axi_read(6'h0C, 32'h0000_0078, OKAY, 3);
  endtask

  task automatic test_slverr();
    axi_write(6'h00, 32'h0000_0055, 4'hF, OKAY, 16'h0001, 0, 0);
    axi_write(6'h10, 32'h0000_DEAD, 4'hF, SLVERR, 16'h0000, 0, 0);
    axi_read(6'h10, 32'h0000_0000, SLVERR, 0);
    axi_read(6'h3C, 32'h0000_0000, SLVERR, 0);
    n_checks++;
    if (reg_out_b !== 128'h55) begin
      n_errors++;
      $display("FAIL slverr_reg_out: got %h want %h", reg_out_b, 128'h55);
    end
    axi_read(6'h00, 32'h0000_0055, OKAY, 0);
  endtask

  task automatic test_ro();
    hw_rd_b[127:96] = 32'h1234_5678;
    axi_read(6'h0C, 32'h1234_5678, OKAY, 0);
    axi_write(6'h0C, 32'hFFFF_FFFF, 4'hF, OKAY, 16'h0008, 0, 0);
    hw_rd_b[127:96] = 32'hCAFE_0001;
    axi_read(6'h0C, 32'hCAFE_0001, OKAY, 0);
  endtask

  task automatic test_w1c();
    @(negedge clk); hw_set_b[63:32] = 32'hF;
    @(negedge clk); hw_set_b[63:32] = 32'h0;
    axi_read(6'h04, 32'h0000_000F, OKAY, 0);
    axi_write(6'h04, 32'h0000_0005, 4'hF, OKAY, 16'h0002, 0, 0);
    axi_read(6'h04, 32'h0000_000A, OKAY, 0);
    @(negedge clk); hw_set_b[63:32] = 32'hF;
    @(negedge clk); hw_set_b[63:32] = 32'h0;
    fork
      axi_write(6'h04, 32'h0000_0005, 4'hF, OKAY, 16'h0002, 0, 0);
      begin
        @(negedge clk); hw_set_b[32] = 1'b1;
        @(posedge clk); #1 hw_set_b[32] = 1'b0;
      end
    join
    axi_read(6'h04, 32'h0000_000B, OKAY, 0);
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    awaddr = 6'h00; awvalid = 1'b1; wdata = 32'h5A; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 6'h04; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_pre: bvalid=%b rvalid=%b, want 1/1", bvalid, rvalid);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || reg_out_a !== 512'd0) begin
      n_errors++;
      $display("FAIL abort_async: bvalid=%b rvalid=%b reg_out_zero=%b, want 0/0/1", bvalid, rvalid, reg_out_a == 512'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) axi_read(6'(i * 4), 32'd0, OKAY, 0);
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    hw_rd_b = '0; hw_set_b = '0;
    test_reset();
    test_basic();
    test_strobe();
    test_parallel();
    test_back_to_back_stall();
    sel = 1'b1;
    test_slverr();
    test_ro();
    test_w1c();
    sel = 1'b0;
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
